lms_ctr_spi_slave: RTL and testbench
====================================

Name: lms_ctr_spi_slave

Overview:
- SPI slave (target) with an 8-bit frame, MSB first, mode CPOL=0 / CPHA=1. It is the far end of the DAC/peripheral SPI master link.
- The block oversamples SCLK, MOSI and SS_n in the system clock domain.
- It moves data through rx/tx holding registers with RRDY/TRDY/overrun/underrun status and an interrupt.
- The CPU sees a 3-bit-addressed register port with two-cycle access strobes, in the same style as the existing SPI master.

Parameters:
DATABITS, 8, frame length in bits. Shift and holding registers are DATABITS wide.
SYNC_STAGES, 2, flops in each input synchroniser (minimum 2).
TX_IDLE, 8'h00, byte shifted out when the tx holding register is empty at frame start.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
SCLK  in  1  SPI clock from master, asynchronous to clk
MOSI  in  1  serial data from master
SS_n  in  1  slave select, active low
MISO  out  1  serial data to master
MISO_oe  out  1  MISO output enable (tristate control at top level)
spi_select  in  1  register-port chip select
mem_addr  in  3  register address
read_n  in  1  read request, active low
write_n  in  1  write request, active low
data_from_cpu  in  16  write data
data_to_cpu  out  16  read data, registered
irq  out  1  interrupt, registered

Behaviour:
- Reset (async, active-high). All outputs go to 0: MISO=0, MISO_oe=0, data_to_cpu=0, irq=0. All status bits, the control register and bit_cnt go to 0. tx_holding_primed=0.
- Synchronisers: SCLK, MOSI and SS_n each pass through SYNC_STAGES flops. SS_n synchronises to 1 during reset.
- Edge detect: rise/fall are derived by comparing the synced SCLK with its delayed copy.
- Timing requirement: SCLK high and low times must each be at least SYNC_STAGES+2 clk periods.
- Frame state machine: IDLE -> ACTIVE -> IDLE.
  - IDLE to ACTIVE on the synced SS_n falling edge.
  - On entry to ACTIVE, tx_shift is loaded from tx_holding if primed; tx_holding_primed is cleared and TRDY is set.
  - If tx_holding is not primed on entry, tx_shift loads TX_IDLE and TUR is set.
  - In ACTIVE, MISO_oe=1.
- In ACTIVE, on each SCLK rise: MISO <= tx_shift[DATABITS-1], then tx_shift shifts left by one.
- In ACTIVE, on each SCLK fall: rx_shift <= {rx_shift[DATABITS-2:0], MOSI_sync}, and bit_cnt increments.
- Byte completion is the fall on which bit_cnt reaches DATABITS.
  - rx_holding <= the assembled byte, bit_cnt <= 0.
  - If RRDY was already 1, ROE is set and rx_holding is overwritten. RRDY is then set.
  - tx_shift reloads from tx_holding (or TX_IDLE with TUR set), same rule as frame start, so back-to-back bytes within one SS_n assertion are supported.
- SS_n rising in ACTIVE: go to IDLE, MISO_oe=0, bit_cnt=0. A partial byte is discarded: no RRDY change and no ROE.
- SCLK edges while SS_n is deasserted are ignored.
- Register access strobes:
  - Read strobe = spi_select & ~read_n & ~rd_strobe_q. Write strobe uses write_n in the same way.
  - Each access therefore has its side effects exactly once.
  - data_to_cpu is valid one cycle after the strobe.
- Register map:
  - 0 rx data (r): {8'h0, rx_holding}. A read clears RRDY.
  - 1 tx data (w): if TRDY, tx_holding <= data_from_cpu[7:0], primed=1, TRDY=0. Otherwise TOE is set and data is dropped.
  - 2 status (r/w): {6'h0, SSA, E, RRDY, TRDY, TUR, TOE, ROE, 3'b0}, where E=ROE|TOE|TUR and SSA = synced ~SS_n. Any write clears ROE, TOE and TUR.
  - 3 control (r/w): interrupt enables at the same bit positions [8:3]; other bits read 0.
  - Any other address reads 0; writes to it are ignored.
- Simultaneous events:
  - Byte completion and an rx read in the same cycle: RRDY ends at 1, and no ROE unless RRDY was already 1 before the read.
  - A tx write and a tx_shift load in the same cycle: the load takes the old holding value; the new value becomes primed.
- irq is registered, one cycle after the status change: OR over bits 3..8 of (status AND control).

Test Plan:
- Reset mid-frame (SS_n low, 3 bits clocked) -> MISO_oe=0, status reads 16'h0040 (TRDY only), bit_cnt=0; the next full frame is received correctly.
- Write 8'hA5 to addr 1, then master sends 8'h3C at SCLK=clk/10 -> MISO shows bits 1,0,1,0,0,1,0,1 at the rises; addr 0 reads 16'h003C; RRDY then clears.
- Two bytes 8'h11 then 8'h22 in one SS_n assertion with no CPU read -> ROE=1, rx reads 8'h22; irq asserts one cycle after ROE if control bit3=1.
- Frame starts with tx holding empty -> MISO sends 8'h00, TUR=1, E=1; a status write clears TUR, TOE and ROE.
- Two tx writes without an intervening frame -> the second sets TOE; the first value (not the second) is transmitted.
- SS_n deasserted after 5 SCLK falls -> RRDY stays 0, rx_holding unchanged, MISO_oe=0 within SYNC_STAGES+1 cycles.

Source files
------------

// File: rtl/lms_ctr_spi_slave.sv
`timescale 1ns/1ps
// lms_ctr_spi_slave
//   SPI target, CPOL=0 / CPHA=1, MSB first, DATABITS-bit frames. SCLK, MOSI
//   and SS_n are oversampled in the clk domain. Received bytes land in an rx
//   holding register (RRDY/ROE). Bytes to send are queued in a tx holding
//   register (TRDY/TOE/TUR). A 3-bit-addressed CPU register port raises irq
//   from the enabled status bits.
//
// Ports
//   clk, reset         system clock, asynchronous active-high reset
//   SCLK, MOSI, SS_n   SPI inputs from the master (asynchronous to clk)
//   MISO, MISO_oe      SPI output and its tristate enable
//   spi_select         register-port chip select
//   mem_addr           register address (0 rx, 1 tx, 2 status, 3 control)
//   read_n, write_n    active-low access requests, held for two cycles
//   data_from_cpu      write data
//   data_to_cpu        registered read data, valid one cycle after the strobe
//   irq                registered interrupt
module lms_ctr_spi_slave #(
    parameter int                  DATABITS    = 8,
    parameter int                  SYNC_STAGES = 2,
    parameter logic [DATABITS-1:0] TX_IDLE     = '0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        SCLK,
    input  logic        MOSI,
    input  logic        SS_n,
    output logic        MISO,
    output logic        MISO_oe,
    input  logic        spi_select,
    input  logic [2:0]  mem_addr,
    input  logic        read_n,
    input  logic        write_n,
    input  logic [15:0] data_from_cpu,
    output logic [15:0] data_to_cpu,
    output logic        irq
);

    localparam int                CNT_W    = $clog2(DATABITS + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATABITS - 1);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t state, next_state;

    logic [SYNC_STAGES-1:0] sclk_sync, mosi_sync, ss_sync;
    logic                   sclk_s, mosi_s, ss_s, sclk_d, ss_d;
    logic                   sclk_rise, sclk_fall, ss_fall;
    logic                   frame_start, frame_end, shift_rise, shift_fall;
    logic                   byte_done, load_tx, tx_room;

    logic [DATABITS-1:0]    tx_shift, rx_shift, tx_holding, rx_holding;
    logic [CNT_W-1:0]       bit_cnt;
    logic                   tx_primed, rrdy, roe, toe, tur;
    logic [5:0]             irq_en;
    logic [15:0]            status, rd_data;

    logic rd_q, wr_q, rd_strobe, wr_strobe;
    logic rx_rd, tx_wr, st_wr, ctl_wr;
    logic unused_bits;

    // Only bits [8:0] of the write bus ever carry meaning; the rx shift MSB
    // falls off the end when the completed byte is assembled.
    assign unused_bits = ^{data_from_cpu[15:9], rx_shift[DATABITS-1]};

    // ---------------------------------------------------------------- sync
    // NOTE: sequential state uses non-blocking (<=) so every flop samples the
    // pre-edge value of its neighbours, which is what makes a shift chain work.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sclk_sync <= '0;
            mosi_sync <= '0;
            ss_sync   <= '1;   // deselected while in reset
            sclk_d    <= 1'b0;
            ss_d      <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], SCLK};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], MOSI};
            ss_sync   <= {ss_sync[SYNC_STAGES-2:0], SS_n};
            sclk_d    <= sclk_s;
            ss_d      <= ss_s;
        end
    end

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign ss_s      = ss_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_d;
    assign sclk_fall = ~sclk_s & sclk_d;
    assign ss_fall   = ss_d & ~ss_s;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // NOTE: every signal written here gets a default first so no path leaves
    // one unassigned, which would otherwise infer a latch.
    always_comb begin
        next_state  = state;
        MISO_oe     = 1'b0;
        frame_start = 1'b0;
        frame_end   = 1'b0;
        shift_rise  = 1'b0;
        shift_fall  = 1'b0;
        case (state)
            IDLE: begin
                if (ss_fall) begin
                    next_state  = ACTIVE;
                    frame_start = 1'b1;
                end
            end
            ACTIVE: begin
                MISO_oe = 1'b1;
                if (ss_s) begin
                    // Deselect wins over any SCLK edge seen in the same cycle.
                    next_state = IDLE;
                    frame_end  = 1'b1;
                end else begin
                    shift_rise = sclk_rise;
                    shift_fall = sclk_fall;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    assign byte_done = shift_fall && (bit_cnt == LAST_BIT);
    assign load_tx   = frame_start | byte_done;
    // A load in this cycle empties the holding register, so a write landing
    // in the same cycle is accepted and becomes the next primed byte.
    assign tx_room   = ~tx_primed | load_tx;

    // ---------------------------------------------------------- CPU port
    assign rd_strobe = spi_select & ~read_n & ~rd_q;
    assign wr_strobe = spi_select & ~write_n & ~wr_q;
    assign rx_rd     = rd_strobe && (mem_addr == 3'd0);
    assign tx_wr     = wr_strobe && (mem_addr == 3'd1);
    assign st_wr     = wr_strobe && (mem_addr == 3'd2);
    assign ctl_wr    = wr_strobe && (mem_addr == 3'd3);

    assign status = {6'h0, ~ss_s, roe | toe | tur, rrdy, ~tx_primed,
                     tur, toe, roe, 3'b000};

    always_comb begin
        rd_data = '0;
        case (mem_addr)
            3'd0:    rd_data = 16'(rx_holding);
            3'd2:    rd_data = status;
            3'd3:    rd_data = {7'h0, irq_en, 3'b000};
            default: rd_data = '0;
        endcase
    end

    // ------------------------------------------------------------ datapath
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            MISO        <= 1'b0;
            tx_shift    <= '0;
            rx_shift    <= '0;
            tx_holding  <= '0;
            rx_holding  <= '0;
            bit_cnt     <= '0;
            tx_primed   <= 1'b0;
            rrdy        <= 1'b0;
            roe         <= 1'b0;
            toe         <= 1'b0;
            tur         <= 1'b0;
            irq_en      <= '0;
            rd_q        <= 1'b0;
            wr_q        <= 1'b0;
            data_to_cpu <= '0;
            irq         <= 1'b0;
        end else begin
            rd_q <= spi_select & ~read_n;
            wr_q <= spi_select & ~write_n;

            if (frame_end) bit_cnt <= '0;   // partial byte is dropped

            if (shift_rise) begin
                MISO     <= tx_shift[DATABITS-1];
                tx_shift <= tx_shift << 1;
            end

            if (shift_fall) begin
                rx_shift <= {rx_shift[DATABITS-2:0], mosi_s};
                bit_cnt  <= byte_done ? '0 : bit_cnt + 1'b1;
                if (byte_done) rx_holding <= {rx_shift[DATABITS-2:0], mosi_s};
            end

            // Later assignments win: clears first, then sets, so a status
            // event coinciding with a CPU clear is not lost.
            if (st_wr) begin
                roe <= 1'b0;
                toe <= 1'b0;
                tur <= 1'b0;
            end
            if (rx_rd) rrdy <= 1'b0;
            if (byte_done) begin
                if (rrdy) roe <= 1'b1;   // pre-read value decides overrun
                rrdy <= 1'b1;
            end

            if (load_tx) begin
                if (tx_primed) begin
                    tx_shift  <= tx_holding;
                    tx_primed <= 1'b0;
                end else begin
                    tx_shift <= TX_IDLE;
                    tur      <= 1'b1;
                end
            end

            if (tx_wr) begin
                if (tx_room) begin
                    tx_holding <= data_from_cpu[DATABITS-1:0];
                    tx_primed  <= 1'b1;
                end else begin
                    toe <= 1'b1;
                end
            end

            if (ctl_wr)    irq_en      <= data_from_cpu[8:3];
            if (rd_strobe) data_to_cpu <= rd_data;

            irq <= |(status[8:3] & irq_en);
        end
    end

endmodule

// File: tb/tb_lms_ctr_spi_slave.sv
`timescale 1ns/1ps
// Self-checking bench for lms_ctr_spi_slave: directed scenarios followed by
// random CPU/SPI operations, all checked against a transaction-level model.
module tb_lms_ctr_spi_slave;

    localparam int HALF = 5;   // SCLK half period in clk cycles (clk/10)
    localparam int SYNC = 2;

    logic        clk = 1'b0;
    logic        reset, SCLK, MOSI, SS_n, MISO, MISO_oe;
    logic        spi_select, read_n, write_n, irq;
    logic [2:0]  mem_addr;
    logic [15:0] data_from_cpu, data_to_cpu;

    always #5 clk = ~clk;

    lms_ctr_spi_slave #(.DATABITS(8), .SYNC_STAGES(SYNC), .TX_IDLE(8'h00)) dut (
        .clk(clk), .reset(reset), .SCLK(SCLK), .MOSI(MOSI), .SS_n(SS_n),
        .MISO(MISO), .MISO_oe(MISO_oe), .spi_select(spi_select),
        .mem_addr(mem_addr), .read_n(read_n), .write_n(write_n),
        .data_from_cpu(data_from_cpu), .data_to_cpu(data_to_cpu), .irq(irq)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------------------------------------------- reference model
    logic [7:0] m_rxh, m_txh;
    logic       m_rrdy, m_roe, m_toe, m_tur, m_primed;
    logic [5:0] m_ctrl;
    logic [7:0] frame_data [4];

    task automatic m_reset();
        m_rxh = 0; m_txh = 0; m_rrdy = 0; m_roe = 0; m_toe = 0; m_tur = 0;
        m_primed = 0; m_ctrl = 0;
    endtask

    function automatic logic [15:0] m_status();
        logic e;
        e = m_roe | m_toe | m_tur;
        return {6'h0, 1'b0, e, m_rrdy, ~m_primed, m_tur, m_toe, m_roe, 3'b000};
    endfunction

    function automatic logic m_irq();
        logic [15:0] s;
        s = m_status();
        return |(s[8:3] & m_ctrl);
    endfunction

    // Next byte the slave will shift out: the queued byte, or idle + underrun.
    task automatic m_load(output logic [7:0] b);
        if (m_primed) begin
            b = m_txh;
            m_primed = 0;
        end else begin
            b = 8'h00;
            m_tur = 1;
        end
    endtask

    // ---------------------------------------------------------- CPU side
    task automatic cpu_write(input logic [2:0] a, input logic [15:0] d);
        @(negedge clk);
        spi_select = 1; mem_addr = a; data_from_cpu = d; write_n = 0;
        repeat (2) @(negedge clk);
        write_n = 1; spi_select = 0;
    endtask

    task automatic cpu_read(input logic [2:0] a, output logic [15:0] d);
        @(negedge clk);
        spi_select = 1; mem_addr = a; read_n = 0;
        repeat (2) @(negedge clk);
        d = data_to_cpu;
        read_n = 1; spi_select = 0;
    endtask

    task automatic tx_write(input logic [7:0] d);
        cpu_write(3'd1, {8'($urandom), d});
        if (!m_primed) begin
            m_txh = d;
            m_primed = 1;
        end else begin
            m_toe = 1;
        end
    endtask

    task automatic status_write();
        cpu_write(3'd2, 16'($urandom));
        m_roe = 0; m_toe = 0; m_tur = 0;
    endtask

    task automatic ctrl_write(input logic [15:0] d);
        cpu_write(3'd3, d);
        m_ctrl = d[8:3];
    endtask

    task automatic rx_read();
        logic [15:0] r;
        cpu_read(3'd0, r);
        check("rx_data", r, {8'h00, m_rxh});
        m_rrdy = 0;
    endtask

    task automatic status_read();
        logic [15:0] r;
        cpu_read(3'd2, r);
        check("status", r, m_status());
    endtask

    task automatic ctrl_read();
        logic [15:0] r;
        cpu_read(3'd3, r);
        check("control", r, {7'h0, m_ctrl, 3'b000});
    endtask

    // ---------------------------------------------------------- SPI master
    // Clocks nbits bits of frame_data (MSB first) inside one SS_n assertion;
    // nbits not a multiple of 8 ends with a partial byte.
    task automatic send_frame(input int nbits);
        logic [7:0] cur, cap;
        int         bi;
        @(negedge clk);
        SS_n = 0;
        repeat (HALF) @(negedge clk);
        m_load(cur);
        check("miso_oe_active", MISO_oe, 1'b1);
        cap = 0;
        for (int i = 0; i < nbits; i++) begin
            bi = 7 - (i % 8);
            SCLK = 1;
            MOSI = frame_data[i / 8][bi];
            repeat (HALF) @(negedge clk);
            cap[bi] = MISO;   // master samples just before the falling edge
            SCLK = 0;
            repeat (HALF) @(negedge clk);
            if (bi == 0) begin
                check("miso_byte", cap, cur);
                if (m_rrdy) m_roe = 1;
                m_rxh  = frame_data[i / 8];
                m_rrdy = 1;
                m_load(cur);
            end
        end
        SS_n = 1;
        repeat (SYNC + 1) @(posedge clk);
        #1 check("miso_oe_release", MISO_oe, 1'b0);
        repeat (3) @(negedge clk);
    endtask

    // ----------------------------------------------------------- watchdog
    initial begin
        #900us;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    // ------------------------------------------------------------ stimulus
    initial begin
        reset = 1; SS_n = 1; SCLK = 0; MOSI = 0;
        spi_select = 0; read_n = 1; write_n = 1; mem_addr = 0; data_from_cpu = 0;
        m_reset();
        repeat (3) @(negedge clk);
        reset = 0;
        repeat (3) @(negedge clk);

        // Reset in the middle of a frame: 3 bits clocked, then reset.
        SS_n = 0;
        repeat (HALF) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            SCLK = 1; MOSI = i[0];
            repeat (HALF) @(negedge clk);
            SCLK = 0;
            repeat (HALF) @(negedge clk);
        end
        reset = 1; SS_n = 1;
        #1;
        check("reset_miso_oe", MISO_oe, 1'b0);
        check("reset_miso", MISO, 1'b0);
        check("reset_data_to_cpu", data_to_cpu, 16'h0);
        check("reset_irq", irq, 1'b0);
        repeat (3) @(negedge clk);
        reset = 0;
        m_reset();
        repeat (4) @(negedge clk);
        check("post_reset_status_model", m_status(), 16'h0040);
        status_read();
        frame_data[0] = 8'h5A;
        send_frame(8);
        rx_read();

        // Queued byte transmitted while a byte is received.
        status_write();
        tx_write(8'hA5);
        frame_data[0] = 8'h3C;
        send_frame(8);
        status_read();
        rx_read();
        status_read();

        // Two bytes without a read: overrun, last byte kept, irq on ROE.
        status_write();
        ctrl_write(16'h0008);
        check("irq_before_roe", irq, m_irq());
        frame_data[0] = 8'h11; frame_data[1] = 8'h22;
        send_frame(16);
        check("irq_on_roe", irq, m_irq());
        status_read();
        rx_read();
        ctrl_read();

        // Empty tx holding: idle byte and underrun, then status-write clear.
        ctrl_write(16'h0000);
        frame_data[0] = 8'hC7;
        send_frame(8);
        status_read();
        status_write();
        status_read();
        rx_read();

        // Second tx write without a frame: TOE, first value transmitted.
        tx_write(8'h5A);
        tx_write(8'hC3);
        status_read();
        frame_data[0] = 8'h96;
        send_frame(8);
        rx_read();
        status_write();

        // Partial frame: 5 falls then deselect; nothing received.
        frame_data[0] = 8'hFF;
        send_frame(5);
        status_read();
        rx_read();

        // Random operations against the model.
        for (int n = 0; n < 80; n++) begin
            case ($urandom_range(0, 7))
                0, 1: tx_write(8'($urandom));
                2:    rx_read();
                3:    status_read();
                4:    status_write();
                5:    begin
                          if ($urandom_range(0, 1) == 1) ctrl_write(16'($urandom));
                          else ctrl_read();
                      end
                default: begin
                    for (int k = 0; k < 4; k++) frame_data[k] = 8'($urandom);
                    send_frame($urandom_range(1, 26));
                end
            endcase
            check("irq", irq, m_irq());
        end
        status_read();
        rx_read();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
